// File: rtl/root_host_queue_pkg.sv
// Shared definitions for the host request queue: command op encoding and
// the width of one buffered command entry.
package root_host_queue_pkg;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  // Width of the outstanding-read counter (supports up to 15 reads in flight).
  localparam int OUT_W = 4;

  // One FIFO entry is {op, addr, data}.
  function automatic int cmd_entry_w(input int addr_w, input int data_w);
    return addr_w + data_w + 1;
  endfunction

endpackage

// File: rtl/root_host_queue_sync_fifo.sv
// Synchronous FIFO with registered storage and wrap-bit pointers.
// Push is refused when full, pop is ignored when empty; there is no bypass path.
module root_host_queue_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);

  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // its pre-edge value; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/root_host_queue.sv
// Host-side front end of the root node: buffers host commands in order,
// dispatches them to the root write/read ports and bounds in-flight reads.
module root_host_queue
  import root_host_queue_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   host_op,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [DATA_W-1:0]      host_data,
  output logic                   write_en,
  output logic [ADDR_W-1:0]      write_addr,
  output logic [DATA_W-1:0]      write_data,
  input  logic                   write_rdy,
  output logic                   read_en,
  output logic [ADDR_W-1:0]      read_addr,
  input  logic                   read_rdy,
  input  logic                   rn_data_vld,
  input  logic [DATA_W-1:0]      rn_data,
  output logic                   rn_data_rdy,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  input  logic                   rsp_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [OUT_W-1:0]       outstanding,
  output logic                   rsp_underflow
);

  localparam int               ENTRY_W   = cmd_entry_w(ADDR_W, DATA_W);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               head_op;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;

  logic               write_fire;
  logic               read_fire;
  logic               rsp_xfer;

  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic               underflow_q, underflow_d;

  assign push_entry = {host_op, host_addr, host_data};
  assign {head_op, head_addr, head_data} = head_entry;

  root_host_queue_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (host_valid),
    .push_data_i (push_entry),
    .pop_i       (write_fire || read_fire),
    .pop_data_o  (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign host_ready = !fifo_full;

  // Only the head is ever offered, so a throttled read also blocks later writes.
  assign write_en   = !fifo_empty && (head_op == OP_WRITE);
  assign read_en    = !fifo_empty && (head_op == OP_READ) && (outstanding_q < MAX_OUT_C);
  assign write_addr = head_addr;
  assign write_data = head_data;
  assign read_addr  = head_addr;

  assign write_fire = write_en && write_rdy;
  assign read_fire  = read_en && read_rdy;

  assign rsp_valid   = rn_data_vld;
  assign rsp_data    = rn_data;
  assign rn_data_rdy = rsp_ready;
  assign rsp_xfer    = rn_data_vld && rsp_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    outstanding_d = outstanding_q;
    underflow_d   = underflow_q;
    if (rsp_xfer && (outstanding_q == '0)) begin
      underflow_d = 1'b1;
    end
    if (read_fire && !rsp_xfer) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (rsp_xfer && !read_fire && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      underflow_q   <= underflow_d;
    end
  end

  assign outstanding   = outstanding_q;
  assign rsp_underflow = underflow_q;

endmodule
